fifo_rd_stream: RTL and testbench

//  Read-side drain for the async FIFO: turns the FIFO pop interface (rd_en/f_empty, 1-cycle read latency)

---
 rtl/fifo_rd_stream_pkg.sv | 15 +
 rtl/fifo_rd_stream_if.sv | 40 ++++
 rtl/fifo_rd_stream_skid2.sv | 64 ++++++
 rtl/fifo_rd_stream.sv | 69 ++++++
 tb/tb_fifo_rd_stream.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream_pkg: shared widths and types for the FIFO read-side stream drain.
//   DATAWIDTH_DEF : default FIFO / stream data width
//   CNTWIDTH_DEF  : default delivered-word counter width
//   BUF_DEPTH     : entries in the output skid buffer
package fifo_rd_stream_pkg;

    localparam int unsigned DATAWIDTH_DEF = 8;
    localparam int unsigned CNTWIDTH_DEF  = 16;
    localparam int unsigned BUF_DEPTH     = 2;
    localparam int unsigned BUF_CNTW      = 2;

    // Occupancy of the skid buffer, 0..BUF_DEPTH
    typedef logic [BUF_CNTW-1:0] buf_cnt_t;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO pop port plus valid/ready stream, bundled.
//   rd_en     : pop request to the FIFO
//   f_empty   : FIFO empty flag
//   fifo_dout : FIFO read data, valid the cycle after an accepted rd_en
//   m_valid   : stream data valid
//   m_data    : stream data
//   m_ready   : consumer accept
// master = the drain (fifo_rd_stream); slave = FIFO + consumer side.
interface fifo_rd_stream_if
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
);

    logic                 rd_en;
    logic                 f_empty;
    logic [DATAWIDTH-1:0] fifo_dout;
    logic                 m_valid;
    logic [DATAWIDTH-1:0] m_data;
    logic                 m_ready;

    modport master (
        output rd_en,
        input  f_empty,
        input  fifo_dout,
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  rd_en,
        output f_empty,
        output fifo_dout,
        input  m_valid,
        input  m_data,
        output m_ready
    );

endinterface

// File: rtl/fifo_rd_stream_skid2.sv
// fifo_rd_stream_skid2: 2-entry in-order buffer feeding the stream output.
//   clk, rst_n : clock, async active-low reset
//   push_i     : write din_i this cycle
//   din_i      : word to store
//   pop_i      : oldest entry consumed this cycle (only while valid_o)
//   dout_o     : oldest entry
//   valid_o    : buffer non-empty
//   cnt_o      : occupancy 0..2
module fifo_rd_stream_skid2
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [DATAWIDTH-1:0] din_i,
    input  logic                 pop_i,
    output logic [DATAWIDTH-1:0] dout_o,
    output logic                 valid_o,
    output buf_cnt_t             cnt_o
);

    buf_cnt_t             cnt_q, cnt_d;
    logic [DATAWIDTH-1:0] e0_q, e0_d;
    logic [DATAWIDTH-1:0] e1_q, e1_d;
    logic                 wr_slot;

    // Shift on pop, then write the incoming word behind whatever remains
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        cnt_d   = cnt_q + buf_cnt_t'(push_i) - buf_cnt_t'(pop_i);
        wr_slot = (cnt_q - buf_cnt_t'(pop_i)) != buf_cnt_t'(0);
        if (pop_i) begin
            e0_d = e1_q;
        end
        if (push_i) begin
            if (wr_slot) begin
                e1_d = din_i;
            end else begin
                e0_d = din_i;
            end
        end
    end

    // Buffer storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign dout_o  = e0_q;
    assign valid_o = (cnt_q != buf_cnt_t'(0));
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a 1-cycle-latency FIFO pop port into a full-rate
// valid/ready stream, all in the FIFO read-clock domain.
//   clk_rd   : read-domain clock
//   rst      : async active-low reset
//   en       : allow new FIFO reads (buffered/in-flight words still drain)
//   bus      : FIFO pop port + output stream (master side)
//   busy     : buffer non-empty or a read in flight
//   word_cnt : words delivered since reset, wrapping
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
    parameter int unsigned CNTWIDTH  = CNTWIDTH_DEF
) (
    input  logic                clk_rd,
    input  logic                rst,
    input  logic                en,
    fifo_rd_stream_if.master    bus,
    output logic                busy,
    output logic [CNTWIDTH-1:0] word_cnt
);

    logic                pend_q, pend_d;
    logic [CNTWIDTH-1:0] word_cnt_q, word_cnt_d;
    logic                pop;
    buf_cnt_t            cnt;
    logic [2:0]          credit_c;

    assign pop = bus.m_valid && bus.m_ready;

    // Occupancy after this edge; a new read is only issued if its word will
    // find a free slot when it lands next cycle
    assign credit_c  = 3'(cnt) + 3'(pend_q) - 3'(pop);
    assign bus.rd_en = rst && en && !bus.f_empty && (credit_c < 3'(BUF_DEPTH));

    // Next-state for in-flight flag and delivered counter
    always_comb begin
        pend_d     = bus.rd_en;
        word_cnt_d = word_cnt_q + CNTWIDTH'(pop);
    end

    always_ff @(posedge clk_rd or negedge rst) begin
        if (!rst) begin
            pend_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Word popped last cycle is captured as it arrives on fifo_dout
    fifo_rd_stream_skid2 #(
        .DATAWIDTH (DATAWIDTH)
    ) u_skid (
        .clk     (clk_rd),
        .rst_n   (rst),
        .push_i  (pend_q),
        .din_i   (bus.fifo_dout),
        .pop_i   (pop),
        .dout_o  (bus.m_data),
        .valid_o (bus.m_valid),
        .cnt_o   (cnt)
    );

    assign busy     = (cnt != buf_cnt_t'(0)) || pend_q;
    assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO modelled as queues (write side on clk_wr, read side
// with 1-cycle latency on clk_rd); a queue model of the output buffer predicts
// every output each read cycle, and a write-order scoreboard checks delivery.
module tb_fifo_rd_stream;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    logic          clk_rd = 1'b0;
    logic          clk_wr = 1'b0;
    logic          rst    = 1'b1;
    logic          en     = 1'b0;
    logic          busy;
    logic [CW-1:0] word_cnt;

    fifo_rd_stream_if #(.DATAWIDTH(DW)) bus ();

    fifo_rd_stream #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
        .clk_rd   (clk_rd),
        .rst      (rst),
        .en       (en),
        .bus      (bus),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #15 clk_rd = ~clk_rd;
    initial begin
        #4;
        forever #10 clk_wr = ~clk_wr;
    end

    logic [DW-1:0] fq[$];    // words visible to the read side
    logic [DW-1:0] wq[$];    // words written, not yet visible
    logic [DW-1:0] sb[$];    // expected delivery order
    logic [DW-1:0] mbuf[$];  // model of buffered words, oldest first
    bit            m_pend;
    bit            exp_pop;
    bit            exp_rd;
    bit            rd_smp;
    bit            wr_on;
    logic [CW-1:0] mcnt;
    int            checks;
    int            errors;

    // Writer on its own clock
    always @(posedge clk_wr) begin
        if (wr_on && $urandom_range(0, 2) == 0) wq.push_back(8'($urandom));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive f_empty, then predict and check rd_en
    task automatic settle();
        bus.f_empty = (fq.size() == 0);
        #1;
        exp_pop = (mbuf.size() != 0) && bus.m_ready;
        exp_rd  = rst && en && !bus.f_empty &&
                  ((mbuf.size() + int'(m_pend) - int'(exp_pop)) < 2);
        rd_smp  = bus.rd_en;
        chk("rd_en", 32'(rd_smp), 32'(exp_rd));
    endtask

    // One read-clock cycle: scoreboard handshake, step model, check, drive
    task automatic cycle(input bit en_v, input bit rdy_v);
        if (bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL order: delivered %0h with nothing written", bus.m_data);
            end else begin
                chk("order", 32'(bus.m_data), 32'(sb.pop_front()));
            end
        end
        @(posedge clk_rd);
        if (exp_pop) begin
            void'(mbuf.pop_front());
            mcnt++;
        end
        if (m_pend) mbuf.push_back(bus.fifo_dout);
        m_pend = exp_rd;
        #1;
        chk("m_valid", 32'(bus.m_valid), 32'(mbuf.size() != 0));
        if (mbuf.size() != 0) chk("m_data", 32'(bus.m_data), 32'(mbuf[0]));
        chk("word_cnt", 32'(word_cnt), 32'(mcnt));
        chk("busy", 32'(busy), 32'((mbuf.size() != 0) || m_pend));
        chk("pend_cnt_inv", 32'(dut.pend_q && (dut.cnt > 2'd1)), 32'(0));
        if (rd_smp && fq.size() != 0) bus.fifo_dout = fq.pop_front();
        else bus.fifo_dout = 8'($urandom);
        while (wq.size() != 0) begin
            logic [DW-1:0] w;
            w = wq.pop_front();
            fq.push_back(w);
            sb.push_back(w);
        end
        en          = en_v;
        bus.m_ready = rdy_v;
        settle();
    endtask

    task automatic clear_model();
        mbuf.delete();
        fq.delete();
        wq.delete();
        sb.delete();
        m_pend = 1'b0;
        mcnt   = '0;
    endtask

    // Asynchronous reset in the middle of a read cycle
    task automatic do_reset();
        #3;
        rst = 1'b0;
        #1;
        chk("rst_m_valid", 32'(bus.m_valid), 32'(0));
        chk("rst_m_data", 32'(bus.m_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_word_cnt", 32'(word_cnt), 32'(0));
        chk("rst_rd_en", 32'(bus.rd_en), 32'(0));
        clear_model();
        settle();
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        rst = 1'b1;
        settle();
    endtask

    initial begin
        int n;
        checks          = 0;
        errors          = 0;
        wr_on           = 1'b0;
        bus.m_ready     = 1'b0;
        bus.f_empty     = 1'b1;
        bus.fifo_dout   = '0;
        clear_model();
        exp_pop = 1'b0;
        exp_rd  = 1'b0;
        rd_smp  = 1'b0;

        // Power-on reset
        #2 rst = 1'b0;
        #1;
        chk("por_m_valid", 32'(bus.m_valid), 32'(0));
        chk("por_busy", 32'(busy), 32'(0));
        chk("por_word_cnt", 32'(word_cnt), 32'(0));
        @(posedge clk_rd);
        #1;
        settle();
        cycle(1'b0, 1'b0);
        rst = 1'b1;
        settle();

        // Short random stream, then reset in the middle of it
        wr_on = 1'b1;
        repeat (200) cycle($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
        wr_on = 1'b0;
        do_reset();
        cycle(1'b1, 1'b0);
        chk("rst_release_word_cnt", 32'(word_cnt), 32'(0));

        // Preloaded 1..16 at full rate: 2-cycle latency then one word per cycle
        for (int i = 1; i <= 16; i++) begin
            fq.push_back(8'(i));
            sb.push_back(8'(i));
        end
        en          = 1'b1;
        bus.m_ready = 1'b1;
        settle();
        chk("t2_rd_en_first", 32'(bus.rd_en), 32'(1));
        cycle(1'b1, 1'b1);
        chk("t2_lat_not_yet", 32'(bus.m_valid), 32'(0));
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b1, 1'b1);
            chk("t2_stream_valid", 32'(bus.m_valid), 32'(1));
            chk("t2_stream_data", 32'(bus.m_data), 32'(k));
        end
        repeat (3) cycle(1'b1, 1'b1);
        chk("t2_word_cnt", 32'(word_cnt), 32'(16));
        chk("t2_idle", 32'(busy), 32'(0));

        // Backpressure: exactly two reads issued, head word held, buffer full
        for (int i = 0; i < 8; i++) begin
            fq.push_back(8'(8'h20 + i));
            sb.push_back(8'(8'h20 + i));
        end
        bus.m_ready = 1'b0;
        settle();
        n = int'(bus.rd_en);
        repeat (5) begin
            cycle(1'b1, 1'b0);
            n += int'(bus.rd_en);
        end
        chk("t3_rd_pulses", 32'(n), 32'(2));
        chk("t3_data_held", 32'(bus.m_data), 32'(8'h20));
        chk("t3_buf_full", 32'(dut.cnt), 32'(2));
        repeat (12) cycle(1'b1, 1'b1);
        chk("t3_all_delivered", 32'(sb.size()), 32'(0));
        chk("t3_word_cnt", 32'(word_cnt), 32'(24));

        // Empty FIFO with garbage on fifo_dout, then a single 0xA5
        repeat (5) cycle(1'b1, 1'b1);
        chk("t4_rd_en_idle", 32'(bus.rd_en), 32'(0));
        chk("t4_valid_idle", 32'(bus.m_valid), 32'(0));
        fq.push_back(8'hA5);
        sb.push_back(8'hA5);
        settle();
        n = 0;
        repeat (6) begin
            cycle(1'b1, 1'b1);
            if (bus.m_valid && bus.m_ready && bus.m_data == 8'hA5) n++;
        end
        chk("t4_a5_once", 32'(n), 32'(1));

        // en drops with one word in flight: it still arrives, nothing more is read
        for (int i = 0; i < 4; i++) begin
            fq.push_back(8'(8'h50 + i));
            sb.push_back(8'(8'h50 + i));
        end
        settle();
        chk("t5_rd_en_before", 32'(bus.rd_en), 32'(1));
        cycle(1'b0, 1'b1);
        n = int'(bus.rd_en);
        repeat (5) begin
            cycle(1'b0, 1'b1);
            n += int'(bus.rd_en);
        end
        chk("t5_no_more_reads", 32'(n), 32'(0));
        chk("t5_busy_low", 32'(busy), 32'(0));
        chk("t5_word_cnt", 32'(word_cnt), 32'(26));
        chk("t5_fifo_left", 32'(fq.size()), 32'(3));
        repeat (10) cycle(1'b1, 1'b1);

        // Long random run with the writer on its own clock
        wr_on = 1'b1;
        repeat (3000) cycle($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)));
        wr_on = 1'b0;
        repeat (60) cycle(1'b1, 1'b1);
        chk("t6_drained", 32'(sb.size()), 32'(0));
        chk("t6_idle", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
